// File: rtl/gray_pkg.sv
// Shared constants and binary/Gray conversion helpers for the Gray counter slice.
// Helpers operate on the widest supported counter; callers resize at the boundary.
package gray_pkg;

  localparam int GRAY_WIDTH_DEF = 4;
  localparam int GRAY_MIN_W     = 2;
  localparam int GRAY_MAX_W     = 16;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t b2g(input gray_word_t x);
    return x ^ (x >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic gray_word_t g2b(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_b2g.sv
// Combinational binary-to-Gray converter feeding the counter's Gray register.
module gray_b2g
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  gray_word_t bin_wide;
  gray_word_t gray_wide;

  assign bin_wide  = gray_word_t'(bin);
  assign gray_wide = b2g(bin_wide);
  assign gray      = gray_wide[WIDTH-1:0];

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray-code counter with load, enable, optional saturation and terminal-count flag.
// Down counting exists only when GRAY_DOWN_EN is defined; otherwise dir is ignored.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH    = GRAY_WIDTH_DEF,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc
);

  logic [WIDTH-1:0] bin_p0;
  logic [WIDTH-1:0] gray_p0;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic             hold_sat;

`ifdef GRAY_DOWN_EN
  always_comb begin
    term_val = dir ? '0 : '1;
    step_val = dir ? (bin_p0 - WIDTH'(1)) : (bin_p0 + WIDTH'(1));
  end
`else
  logic unused_dir;
  assign unused_dir = dir;

  always_comb begin
    term_val = '1;
    step_val = bin_p0 + WIDTH'(1);
  end
`endif

  assign at_term  = (bin_p0 == term_val);
  assign hold_sat = (SATURATE != 0) && at_term;

  // rst gating keeps tc low while the register is being held clear.
  assign tc = rst && clk_en && !ld && at_term;

  always_comb begin
    bin_nxt = bin_p0;
    if (clk_en) begin
      if (ld) begin
        bin_nxt = ld_val;
      end else if (!hold_sat) begin
        bin_nxt = step_val;
      end
    end
  end

  gray_b2g #(
    .WIDTH (WIDTH)
  ) u_b2g (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  // Stage p0: binary and Gray registers share one edge, so they never disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_p0  <= '0;
      gray_p0 <= '0;
    end else begin
      bin_p0  <= bin_nxt;
      gray_p0 <= gray_nxt;
    end
  end

  assign bin_out  = bin_p0;
  assign gray_out = gray_p0;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: a wrapping and a saturating instance share stimulus.
module tb_gray_counter_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       dir;
  logic       ld;
  logic [3:0] ld_val;
  logic [3:0] gray0, bin0, gray1, bin1;
  logic       tc0, tc1;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dir(dir), .ld(ld), .ld_val(ld_val),
    .gray_out(gray0), .bin_out(bin0), .tc(tc0)
  );

  gray_counter_n #(.WIDTH(4), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .clk_en(clk_en), .dir(dir), .ld(ld), .ld_val(ld_val),
    .gray_out(gray1), .bin_out(bin1), .tc(tc1)
  );

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string tag, input logic [3:0] eb0, input logic [3:0] eb1);
    chk({tag, " bin0"}, 16'(bin0), 16'(eb0));
    chk({tag, " gray0"}, 16'(gray0), 16'(to_gray(eb0)));
    chk({tag, " bin1"}, 16'(bin1), 16'(eb1));
    chk({tag, " gray1"}, 16'(gray1), 16'(to_gray(eb1)));
  endtask

  // Per-cycle invariants: Gray matches binary, and a plain count step flips one Gray bit.
  logic [3:0] pre_g0;
  logic       pre_step = 1'b0;

  always @(posedge clk) begin
    pre_g0   = gray0;
    pre_step = rst && clk_en && !ld;
  end

  always @(negedge clk) begin
    chk("inv gray0==b2g(bin0)", 16'(gray0), 16'(to_gray(bin0)));
    chk("inv gray1==b2g(bin1)", 16'(gray1), 16'(to_gray(bin1)));
    if (pre_step && rst) begin
      chk("inv one-bit change", 16'($countones(gray0 ^ pre_g0)), 16'd1);
    end
  end

  initial begin
    rst = 1'b0; clk_en = 1'b1; dir = 1'b0; ld = 1'b0; ld_val = 4'h0;
    step();
    step();
    chk_both("reset", 4'h0, 4'h0);
    chk("reset tc0", 16'(tc0), 16'd0);
    chk("reset tc1", 16'(tc1), 16'd0);

    rst = 1'b1;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("up gray0 table", 16'(gray0), 16'(gtab[i]));
      chk_both("up", 4'(i), 4'(i));
      if (i < 15) chk("up tc0 low", 16'(tc0), 16'd0);
    end
    chk("terminal tc0", 16'(tc0), 16'd1);
    chk("terminal tc1", 16'(tc1), 16'd1);

    step();
    chk_both("wrap/hold", 4'h0, 4'hF);
    chk("after wrap tc0", 16'(tc0), 16'd0);
    chk("sat hold tc1", 16'(tc1), 16'd1);
    step();
    chk_both("sat hold 2", 4'h1, 4'hF);

    ld = 1'b1; ld_val = 4'h5;
    #1;
    chk("ld masks tc1", 16'(tc1), 16'd0);
    step();
    chk_both("load 0101", 4'h5, 4'h5);
    chk("load gray0 0111", 16'(gray0), 16'h7);

    clk_en = 1'b0; ld_val = 4'h9;
    step();
    chk_both("ld with clk_en=0", 4'h5, 4'h5);
    ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_both("frozen", 4'h5, 4'h5);
      chk("frozen tc0", 16'(tc0), 16'd0);
    end
    clk_en = 1'b1;
    step();
    chk_both("resume", 4'h6, 4'h6);

    for (int i = 7; i < 16; i++) step();
    chk_both("second terminal", 4'hF, 4'hF);
    step();
    chk_both("wrap vs sat", 4'h0, 4'hF);
    ld = 1'b1; ld_val = 4'h0;
    step();
    chk_both("load overrides sat", 4'h0, 4'h0);
    ld = 1'b0;

    step();
    step();
    step();
    chk_both("pre async", 4'h3, 4'h3);
    #2 rst = 1'b0;
    #1;
    chk_both("async reset", 4'h0, 4'h0);
    chk("async tc0", 16'(tc0), 16'd0);
    #1 rst = 1'b1;
    step();
    chk_both("step from 0", 4'h1, 4'h1);

`ifdef GRAY_DOWN_EN
    rst = 1'b0; dir = 1'b1;
    #1;
    chk("down tc in reset", 16'(tc0), 16'd0);
    step();
    rst = 1'b1;
    #1;
    chk("down tc at 0", 16'(tc0), 16'd1);
    step();
    chk_both("down wrap", 4'hF, 4'h0);
    chk("down gray 1000", 16'(gray0), 16'h8);
    chk("down sat tc1", 16'(tc1), 16'd1);
    step();
    chk_both("down 1110", 4'hE, 4'h0);
    chk("down gray 1001", 16'(gray0), 16'h9);
    dir = 1'b0;
    step();
    chk_both("dir flip", 4'hF, 4'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
